// File: rtl/rx_stream_pkg.sv
// Shared constants and FSM encoding for the receiver page streamer.
// The CRC constants are used only when the design is built with STREAM_CRC_EN.
package rx_stream_pkg;

  localparam int WORDS_PER_PAGE = 82;
  localparam int BYTES_PER_WORD = 6;

  localparam logic [7:0]  SYNC0    = 8'hAA;
  localparam logic [7:0]  SYNC1    = 8'h55;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam logic [6:0] LAST_WORD = 7'(WORDS_PER_PAGE - 1);
  localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_WORD - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_RD,
    ST_WAIT,
    ST_LOAD,
    ST_BYTE,
    ST_CRCH,
    ST_CRCL,
    ST_TAIL
  } state_t;

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Combinational CRC-16/CCITT update for one byte, MSB first.
// Instantiated by rx_page_streamer only when STREAM_CRC_EN is defined.
module crc16_ccitt_byte
  import rx_stream_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  always_comb begin
    logic [15:0] c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/rx_page_streamer.sv
// Streams each completed ping-pong page as a framed byte packet (AA 55 seq payload).
// Optional CRC-16 trailer over the payload is enabled by defining STREAM_CRC_EN.
//
// state | meaning
// IDLE  | waiting for a pending page
// HDR0  | sending SYNC0
// HDR1  | sending SYNC1
// HDR2  | sending sequence number
// RD    | issuing RAM read address
// WAIT  | RAM latency cycle
// LOAD  | capturing the read word into the shifter
// BYTE  | sending the shifter's top byte
// CRCH  | sending CRC high byte (STREAM_CRC_EN only)
// CRCL  | sending CRC low byte (STREAM_CRC_EN only)
// TAIL  | bumping seq, packet done
module rx_page_streamer
  import rx_stream_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_on,
  input  logic        mem_block,
  output logic [7:0]  rd_addr,
  input  logic [47:0] rd_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun,
  output logic [7:0]  seq
);

`ifdef STREAM_CRC_EN
  localparam state_t ST_AFTER_PAYLOAD = ST_CRCH;
`else
  localparam state_t ST_AFTER_PAYLOAD = ST_TAIL;
`endif

  state_t      state, state_nxt;
  logic        pending, mb_last, armed, page;
  logic [6:0]  word;
  logic [2:0]  bcnt;
  logic [47:0] sh;
  logic        accept, toggle, busy, last_byte;

  assign accept    = out_valid && out_ready;
  assign toggle    = armed && (mem_block != mb_last);
  // TAIL always leaves for IDLE, so a page arriving there is queued without overrun
  assign busy      = (state != ST_IDLE) && (state != ST_TAIL);
  assign last_byte = (bcnt == LAST_BYTE);

`ifdef STREAM_CRC_EN
  logic [15:0] crc, crc_nxt;

  crc16_ccitt_byte u_crc (
    .crc_in  (crc),
    .data    (sh[47:40]),
    .crc_out (crc_nxt)
  );
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else if (!rx_on) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    out_data  = 8'h00;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: if (pending) state_nxt = ST_HDR0;
      ST_HDR0: begin
        out_data  = SYNC0;
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_HDR1;
      end
      ST_HDR1: begin
        out_data  = SYNC1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_HDR2;
      end
      ST_HDR2: begin
        out_data  = seq;
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_RD;
      end
      ST_RD:   state_nxt = ST_WAIT;
      ST_WAIT: state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_BYTE;
      ST_BYTE: begin
        out_data  = sh[47:40];
        out_valid = 1'b1;
        if (out_ready && last_byte)
          state_nxt = (word == LAST_WORD) ? ST_AFTER_PAYLOAD : ST_RD;
      end
`ifdef STREAM_CRC_EN
      ST_CRCH: begin
        out_data  = crc[15:8];
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_CRCL;
      end
      ST_CRCL: begin
        out_data  = crc[7:0];
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_TAIL;
      end
`endif
      ST_TAIL: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      mb_last <= 1'b0;
      armed   <= 1'b0;
      overrun <= 1'b0;
      seq     <= 8'h00;
      rd_addr <= 8'h00;
      page    <= 1'b0;
      word    <= 7'd0;
      bcnt    <= 3'd0;
      sh      <= 48'h0;
`ifdef STREAM_CRC_EN
      crc     <= CRC_INIT;
`endif
    end else if (!rx_on) begin
      pending <= 1'b0;
      mb_last <= mem_block;
      armed   <= 1'b1;
      overrun <= 1'b0;
      seq     <= 8'h00;
      rd_addr <= 8'h00;
      page    <= 1'b0;
      word    <= 7'd0;
      bcnt    <= 3'd0;
      sh      <= 48'h0;
`ifdef STREAM_CRC_EN
      crc     <= CRC_INIT;
`endif
    end else begin
      // First enabled cycle after reset adopts the current page index without a toggle
      if (!armed) begin
        armed   <= 1'b1;
        mb_last <= mem_block;
      end else if (toggle) begin
        mb_last <= mem_block;
        if (busy) overrun <= 1'b1;
      end

      if (toggle)
        pending <= 1'b1;
      else if (state == ST_IDLE && pending)
        pending <= 1'b0;

      case (state)
        ST_IDLE: if (pending) begin
          page <= mb_last;
          word <= 7'd0;
`ifdef STREAM_CRC_EN
          crc  <= CRC_INIT;
`endif
        end
        ST_RD:   rd_addr <= {page, word};
        ST_LOAD: begin
          sh   <= rd_data;
          bcnt <= 3'd0;
        end
        ST_BYTE: if (accept) begin
          sh   <= {sh[39:0], 8'h00};
          bcnt <= bcnt + 3'd1;
`ifdef STREAM_CRC_EN
          crc  <= crc_nxt;
`endif
          if (last_byte && word != LAST_WORD) word <= word + 7'd1;
        end
        ST_TAIL: seq <= seq + 8'd1;
        default: ;
      endcase
    end
  end

endmodule
